// File: rtl/mem_write_monitor.sv
// mem_write_monitor
// End-of-test monitor for the MIPS cores. Snoops the data-memory write port,
// scores up to NUM_CHECKS expected address/data writes (any order, or strict
// ascending order when ORDERED=1), ends the test on a write to FINISH_ADDR,
// enforces a cycle timeout and holds a sticky pass/fail verdict.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   memwrite             data-memory write strobe
//   dataadr, writedata   write address and data
//   chk_en               per-channel enable (static while running)
//   chk_addr, chk_data   expected address/data, channel i at [i*WIDTH +: WIDTH]
//   done, pass           verdict reached / verdict is a pass
//   fail_code, fail_idx  failure reason (1 mismatch, 2 order, 3 missing,
//                        4 timeout) and offending channel
//   hit_mask             channels hit with correct data
//   cycle_cnt, wr_cnt    saturating RUN cycle and write counters
module mem_write_monitor #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_CHECKS  = 4,
  parameter logic [WIDTH-1:0] FINISH_ADDR = 'h4C,
  parameter int               TIMEOUT     = 100000,
  parameter bit               ORDERED     = 1'b0,
  parameter int               CNT_W       = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        memwrite,
  input  logic [WIDTH-1:0]            dataadr,
  input  logic [WIDTH-1:0]            writedata,
  input  logic [NUM_CHECKS-1:0]       chk_en,
  input  logic [NUM_CHECKS*WIDTH-1:0] chk_addr,
  input  logic [NUM_CHECKS*WIDTH-1:0] chk_data,
  output logic                        done,
  output logic                        pass,
  output logic [2:0]                  fail_code,
  output logic [3:0]                  fail_idx,
  output logic [NUM_CHECKS-1:0]       hit_mask,
  output logic [CNT_W-1:0]            cycle_cnt,
  output logic [CNT_W-1:0]            wr_cnt
);

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL} state_e;

  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_MISMATCH = 3'd1;
  localparam logic [2:0] CODE_ORDER    = 3'd2;
  localparam logic [2:0] CODE_MISSING  = 3'd3;
  localparam logic [2:0] CODE_TIMEOUT  = 3'd4;

  state_e                state_q, state_d;
  logic                  pass_q, pass_d;
  logic [2:0]            code_q, code_d;
  logic [3:0]            idx_q, idx_d;
  logic [NUM_CHECKS-1:0] hit_mask_q, hit_mask_d;
  logic [CNT_W-1:0]      cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]      wr_cnt_q, wr_cnt_d;

  // Per-channel address match (only on real writes) and data compare.
  logic [NUM_CHECKS-1:0] addr_hit;
  logic [NUM_CHECKS-1:0] data_ok;

  generate
    for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_chk
      assign addr_hit[gi] = memwrite && chk_en[gi] &&
                            (dataadr == chk_addr[gi*WIDTH +: WIDTH]);
      assign data_ok[gi]  = (writedata == chk_data[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  // Scoring of this cycle's write. Channels are walked in ascending order so
  // that a lower channel hit in this same cycle already counts as "earlier"
  // for the ordering rule, and the first offender found is the lowest index.
  logic [NUM_CHECKS-1:0] hit_new;
  logic                  prefix_ok;
  logic                  mis_found, ord_found, miss_found;
  logic [3:0]            mis_idx, ord_idx, miss_idx;

  always_comb begin
    hit_new    = hit_mask_q;
    prefix_ok  = 1'b1;
    mis_found  = 1'b0;
    mis_idx    = '0;
    ord_found  = 1'b0;
    ord_idx    = '0;
    miss_found = 1'b0;
    miss_idx   = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      if (addr_hit[i]) begin
        if (!data_ok[i]) begin
          if (!mis_found) begin
            mis_found = 1'b1;
            mis_idx   = 4'(i);
          end
        end else if (ORDERED && !prefix_ok) begin
          if (!ord_found) begin
            ord_found = 1'b1;
            ord_idx   = 4'(i);
          end
        end else begin
          hit_new[i] = 1'b1;
        end
      end
      prefix_ok = prefix_ok && (!chk_en[i] || hit_new[i]);
    end
    // Lowest enabled channel still unhit, for the missing-check verdict.
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (chk_en[i] && !hit_new[i]) begin
        miss_found = 1'b1;
        miss_idx   = 4'(i);
      end
    end
  end

  logic finish_wr;
  logic timeout_hit;
  assign finish_wr   = memwrite && (dataadr == FINISH_ADDR);
  assign timeout_hit = (cycle_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    pass_d      = pass_q;
    code_d      = code_q;
    idx_d       = idx_q;
    hit_mask_d  = hit_mask_q;
    cycle_cnt_d = cycle_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    if (state_q == S_RUN) begin
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      if (memwrite && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
      hit_mask_d = hit_new;
      if (mis_found) begin
        state_d = S_FAIL;
        code_d  = CODE_MISMATCH;
        idx_d   = mis_idx;
      end else if (ord_found) begin
        state_d = S_FAIL;
        code_d  = CODE_ORDER;
        idx_d   = ord_idx;
      end else if (finish_wr) begin
        if (!miss_found) begin
          state_d = S_PASS;
          pass_d  = 1'b1;
          code_d  = CODE_NONE;
          idx_d   = '0;
        end else begin
          state_d = S_FAIL;
          code_d  = CODE_MISSING;
          idx_d   = miss_idx;
        end
      end else if (timeout_hit) begin
        state_d = S_FAIL;
        code_d  = CODE_TIMEOUT;
        idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      pass_q      <= 1'b0;
      code_q      <= CODE_NONE;
      idx_q       <= '0;
      hit_mask_q  <= '0;
      cycle_cnt_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      code_q      <= code_d;
      idx_q       <= idx_d;
      hit_mask_q  <= hit_mask_d;
      cycle_cnt_q <= cycle_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign done      = (state_q != S_RUN);
  assign pass      = pass_q;
  assign fail_code = code_q;
  assign fail_idx  = idx_q;
  assign hit_mask  = hit_mask_q;
  assign cycle_cnt = cycle_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Synthesizable end-of-test monitor for the MIPS cores, generalising the fixed "stop when dataadr hits 0x4C" bench check.
- Snoops the data-memory write port (memwrite, dataadr, writedata) and scores up to NUM_CHECKS expected address/data writes, in any order or in strict order.
- Detects a finish write and enforces a cycle timeout.
- Latches a sticky pass/fail verdict that benches and FPGA LEDs can read.

Parameters:
- WIDTH, 32: data/address width.
- NUM_CHECKS, 4: number of address/data check channels (1..16).
- FINISH_ADDR, 32'h4C: a write to this address ends the test.
- TIMEOUT, 100000: cycles in RUN before a timeout verdict (≥2).
- ORDERED, 0: 1 means enabled checks must be hit in ascending index order.
- CNT_W, 32: width of the cycle and write counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  1  data-memory write strobe.
- dataadr  in  WIDTH  data-memory address.
- writedata  in  WIDTH  data being written.
- chk_en  in  NUM_CHECKS  per-channel enable; static while running.
- chk_addr  in  NUM_CHECKS*WIDTH  expected addresses; channel i occupies bits [i*WIDTH +: WIDTH].
- chk_data  in  NUM_CHECKS*WIDTH  expected data, same packing.
- done  out  1  verdict reached (sticky).
- pass  out  1  test passed (valid when done).
- fail_code  out  3  0 none, 1 data mismatch, 2 order violation, 3 missing check, 4 timeout.
- fail_idx  out  4  offending channel index (0 for timeout and pass).
- hit_mask  out  NUM_CHECKS  channels hit with correct data.
- cycle_cnt  out  CNT_W  cycles spent in RUN, saturating.
- wr_cnt  out  CNT_W  memwrite cycles seen in RUN, saturating.

Behaviour:
- States: RUN, PASS, FAIL. reset=1 forces RUN on the next edge.
- Reset values: done, pass, fail_code, fail_idx, hit_mask, cycle_cnt and wr_cnt all 0. Reset mid-test discards everything; there is no memory of the prior run.
- RUN, every cycle: cycle_cnt++ (saturate at all-ones).
- RUN, when memwrite=1: wr_cnt++ (saturate). For each channel i with chk_en[i]=1 and dataadr==chk_addr[i]:
  - writedata==chk_data[i] → set hit_mask[i]. Repeat hits are harmless.
  - writedata!=chk_data[i] → mismatch on channel i.
- ORDERED=1: a correct hit on channel i while any enabled j<i is not yet hit is an order violation on i, and hit_mask[i] is not set.
- Several channels sharing an address are all evaluated in the same cycle. The lowest offending index is reported.
- Finish: memwrite=1 and dataadr==FINISH_ADDR. The verdict uses hit_mask including any hits made in this same cycle.
  - All enabled channels hit → PASS: done=1, pass=1, fail_code=0.
  - Otherwise → FAIL, code 3, fail_idx = lowest enabled unhit channel.
  - If FINISH_ADDR is also a check address, that write is scored first.
- Priority within one cycle: mismatch (1) > order (2) > finish verdict > timeout (4). Any mismatch or order violation goes to FAIL immediately, without waiting for finish.
- Timeout: if the incoming cycle_cnt==TIMEOUT-1 and no finish/failure occurs this cycle → FAIL, code 4. The verdict appears TIMEOUT cycles after reset deassert.
- Write with memwrite=0: ignored entirely, including at FINISH_ADDR.
- chk_en all zero: first finish write → PASS.
- Verdict timing: PASS/FAIL outputs are registered, visible one cycle after the deciding edge's inputs.
- PASS/FAIL are terminal until reset. Counters and hit_mask freeze and further writes are ignored.
- No combinational path from inputs to outputs.

Test Plan:
- Basic pass: ch0=(0x54, 7) enabled. Write 7 to 0x54, then write anything to 0x4C → done=1, pass=1, hit_mask=0001, wr_cnt=2.
- Mismatch: ch1=(0x50, 0x12). Write 0x13 to 0x50 → next cycle done=1, fail_code=1, fail_idx=1. A later 0x4C write causes no change.
- Missing: ch0 and ch2 enabled, only ch2 written correctly, then finish → fail_code=3, fail_idx=0, hit_mask=0100.
- Ordered: ORDERED=1, ch0=(0x40, 1), ch1=(0x44, 2). Write 2 to 0x44 first → fail_code=2, fail_idx=1, hit_mask=0000. Correct order then finish → pass.
- Timeout: TIMEOUT=20, no writes → done=1, fail_code=4 after exactly 20 RUN cycles, cycle_cnt=20. With finish at cycle 19 instead → PASS (finish beats timeout).
- Reset mid-run: after hit_mask=0001 and wr_cnt=3, pulse reset 1 cycle → all outputs 0. A fresh test then passes normally; memwrite=0 with dataadr=0x4C never finishes.
